// File: rtl/leaf_shell_pkg.sv
// Shared constants and width helpers for the leaf shell blocks.
package leaf_shell_pkg;

    localparam int PAYLOAD_BITS_DEFAULT = 32;
    localparam int WORD_CNT_BITS        = 32;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Index width that never collapses to zero bits, even for one or two entries.
    function automatic int idxBits(input int value);
        return (value <= 2) ? 1 : clog2(value);
    endfunction

endpackage

// File: rtl/leaf_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered occupancy count.
// Full and empty come from the registered count, so a pop never makes room for a push in the same cycle.
module leaf_sync_fifo
    import leaf_shell_pkg::*;
#(
    parameter int WIDTH = PAYLOAD_BITS_DEFAULT,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = idxBits(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign data_o  = mem_q[rdPtr_q];

    always_comb begin
        count_d = count_q;
        if (doPush && !doPop) begin
            count_d = count_q + CW'(1);
        end else if (!doPush && doPop) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/leaf_user_rr_merge.sv
// Merges NUM_IN_PORTS inputs onto NUM_OUT_PORTS outputs (input i -> output i mod NUM_OUT_PORTS),
// round-robin per group, one FWFT FIFO per output. Define LEAF_RR_MERGE_CNT_EN for per-output transfer counters.
module leaf_user_rr_merge
    import leaf_shell_pkg::*;
#(
    parameter int PAYLOAD_BITS  = PAYLOAD_BITS_DEFAULT,
    parameter int NUM_IN_PORTS  = 5,
    parameter int NUM_OUT_PORTS = 3,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                                    clk_user,
    input  logic                                    reset,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]                 vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]                 ack_user2interface,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    output logic [NUM_OUT_PORTS*WORD_CNT_BITS-1:0]  word_cnt
);

    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : gGroup
        localparam int MEMBERS = (NUM_IN_PORTS - j + NUM_OUT_PORTS - 1) / NUM_OUT_PORTS;
        localparam int MW      = idxBits(MEMBERS);

        logic [MEMBERS-1:0]      req;
        logic [PAYLOAD_BITS-1:0] memberData [MEMBERS];
        logic [MW-1:0]           ptr_q;
        logic [MW-1:0]           ptr_d;
        logic [MW-1:0]           scanIdx;
        logic [MW-1:0]           grantIdx;
        logic                    found;
        logic                    full;
        logic                    empty;
        logic                    popReq;

        // Member m of this group is input j + m*NUM_OUT_PORTS; the pointer holds a member index.
        for (genvar m = 0; m < MEMBERS; m++) begin : gMember
            assign req[m]        = vld_interface2user[j + m*NUM_OUT_PORTS];
            assign memberData[m] = dout_leaf_interface2user[(j + m*NUM_OUT_PORTS)*PAYLOAD_BITS +: PAYLOAD_BITS];
            assign ack_user2interface[j + m*NUM_OUT_PORTS] = found && (grantIdx == MW'(m));
        end

        always_comb begin
            found    = 1'b0;
            grantIdx = '0;
            scanIdx  = '0;
            ptr_d    = ptr_q;
            if (!reset && !full) begin
                for (int o = 0; o < MEMBERS; o++) begin
                    scanIdx = MW'((int'(ptr_q) + o) % MEMBERS);
                    if (!found && req[scanIdx]) begin
                        found    = 1'b1;
                        grantIdx = scanIdx;
                    end
                end
            end
            if (found) begin
                ptr_d = (int'(grantIdx) == MEMBERS - 1) ? '0 : grantIdx + MW'(1);
            end
        end

        always_ff @(posedge clk_user) begin
            if (reset) begin
                ptr_q <= '0;
            end else begin
                ptr_q <= ptr_d;
            end
        end

        leaf_sync_fifo #(
            .WIDTH (PAYLOAD_BITS),
            .DEPTH (FIFO_DEPTH)
        ) uFifo (
            .clk_i   (clk_user),
            .reset_i (reset),
            .push_i  (found),
            .data_i  (memberData[grantIdx]),
            .pop_i   (popReq),
            .data_o  (din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .full_o  (full),
            .empty_o (empty)
        );

        assign vld_user2interface[j] = !empty && !reset;
        assign popReq                = vld_user2interface[j] && ack_interface2user[j];

`ifdef LEAF_RR_MERGE_CNT_EN
        logic [WORD_CNT_BITS-1:0] cnt_q;

        always_ff @(posedge clk_user) begin
            if (reset) begin
                cnt_q <= '0;
            end else if (popReq && (cnt_q != '1)) begin
                cnt_q <= cnt_q + WORD_CNT_BITS'(1);
            end
        end

        assign word_cnt[j*WORD_CNT_BITS +: WORD_CNT_BITS] = cnt_q;
`else
        assign word_cnt[j*WORD_CNT_BITS +: WORD_CNT_BITS] = '0;
`endif
    end

endmodule

// File: tb/tb_leaf_user_rr_merge.sv
// Bench for leaf_user_rr_merge: directed scenarios plus random traffic against a queue-based reference model.
module tb_leaf_user_rr_merge;

    localparam int PB    = 32;
    localparam int NIN   = 5;
    localparam int NOUT  = 3;
    localparam int DEPTH = 4;

    logic                clk_user = 1'b0;
    logic                reset;
    logic [NIN*PB-1:0]   inData;
    logic [NIN-1:0]      inVld;
    logic [NIN-1:0]      ackIn;
    logic [NOUT*PB-1:0]  outData;
    logic [NOUT-1:0]     outVld;
    logic [NOUT-1:0]     outAck;
    logic [NOUT*32-1:0]  wordCnt;

    int total = 0;
    int bad   = 0;

    logic [PB-1:0] refQ [NOUT][$];
    int            refPtr [NOUT];
    longint        refCnt [NOUT];
    int            sentCnt [NIN];

    always #5 clk_user = ~clk_user;

    leaf_user_rr_merge #(
        .PAYLOAD_BITS  (PB),
        .NUM_IN_PORTS  (NIN),
        .NUM_OUT_PORTS (NOUT),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk_user                 (clk_user),
        .reset                    (reset),
        .dout_leaf_interface2user (inData),
        .vld_interface2user       (inVld),
        .ack_user2interface       (ackIn),
        .din_leaf_user2interface  (outData),
        .vld_user2interface       (outVld),
        .ack_interface2user       (outAck),
        .word_cnt                 (wordCnt)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // First requesting input at or after the pointer, ascending within the group, wrapping to the lowest member.
    function automatic int refGrant(input int j);
        for (int i = refPtr[j]; i < NIN; i += NOUT) if (inVld[i]) return i;
        for (int i = j; i < refPtr[j]; i += NOUT) if (inVld[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] expCnt(input int j);
`ifdef LEAF_RR_MERGE_CNT_EN
        return refCnt[j][31:0];
`else
        return 32'd0;
`endif
    endfunction

    // Called just after a rising edge with inputs already driven; checks at the falling edge, then advances the model.
    task automatic stepCycle();
        logic [NIN-1:0] expAck;
        int             g [NOUT];
        logic           expVld;
        @(negedge clk_user);
        expAck = '0;
        for (int j = 0; j < NOUT; j++) begin
            g[j] = -1;
            if (!reset && refQ[j].size() < DEPTH) begin
                g[j] = refGrant(j);
                if (g[j] >= 0) expAck[g[j]] = 1'b1;
            end
        end
        checkOutput("ack", ackIn, expAck);
        for (int j = 0; j < NOUT; j++) begin
            expVld = !reset && (refQ[j].size() > 0);
            checkOutput($sformatf("vld%0d", j), outVld[j], expVld);
            if (expVld) checkOutput($sformatf("data%0d", j), outData[j*PB +: PB], refQ[j][0]);
            if (!reset) checkOutput($sformatf("cnt%0d", j), wordCnt[j*32 +: 32], expCnt(j));
        end
        for (int j = 0; j < NOUT; j++) begin
            if (reset) begin
                refQ[j].delete();
                refPtr[j] = j;
                refCnt[j] = 0;
            end else begin
                if (refQ[j].size() > 0 && outAck[j]) begin
                    void'(refQ[j].pop_front());
                    if (refCnt[j] < 64'hFFFF_FFFF) refCnt[j]++;
                end
                if (g[j] >= 0) begin
                    refQ[j].push_back(inData[g[j]*PB +: PB]);
                    sentCnt[g[j]]++;
                    refPtr[j] = (g[j] + NOUT < NIN) ? g[j] + NOUT : j;
                end
            end
        end
        @(posedge clk_user);
        #1;
    endtask

    task automatic applyStimulus(input logic [NIN-1:0] vldMask, input logic [NOUT-1:0] ackMask);
        inVld  = vldMask;
        outAck = ackMask;
        for (int i = 0; i < NIN; i++) inData[i*PB +: PB] = PB'(i*16 + sentCnt[i]);
    endtask

    task automatic pulseReset();
        reset = 1'b1;
        applyStimulus('0, '0);
        stepCycle();
        reset = 1'b0;
    endtask

    initial begin
        logic [NIN-1:0] ackSeq [4];
        logic [PB-1:0]  ordSeq [4];
        int             ackCount;

        reset  = 1'b1;
        inVld  = '0;
        inData = '0;
        outAck = '0;
        for (int i = 0; i < NIN; i++) sentCnt[i] = 0;
        for (int j = 0; j < NOUT; j++) begin
            refPtr[j] = j;
            refCnt[j] = 0;
        end
        @(posedge clk_user);
        #1;
        stepCycle();
        reset = 1'b0;
        #1;
        checkOutput("rstVld", outVld, '0);
        checkOutput("rstAck", ackIn, '0);

        // Three words on input 0 with the output always accepting.
        for (int k = 0; k < 4; k++) begin
            inVld  = (k < 3) ? 5'b00001 : 5'b00000;
            outAck = 3'b001;
            inData[0 +: PB] = PB'(32'hA0 + k);
            #1;
            if (k > 0) begin
                checkOutput("fwftVld", outVld[0], 1'b1);
                checkOutput("fwftData", outData[0 +: PB], PB'(32'hA0 + k - 1));
            end
            stepCycle();
        end
`ifdef LEAF_RR_MERGE_CNT_EN
        checkOutput("cntAfter3", wordCnt[0 +: 32], 32'd3);
`else
        checkOutput("cntAfter3", wordCnt[0 +: 32], 32'd0);
`endif

        // Inputs 0 and 3 share group 0 and must alternate.
        pulseReset();
        for (int i = 0; i < NIN; i++) sentCnt[i] = 0;
        ackSeq = '{5'b00001, 5'b01000, 5'b00001, 5'b01000};
        ordSeq = '{32'h00, 32'h30, 32'h01, 32'h31};
        for (int k = 0; k < 4; k++) begin
            applyStimulus(5'b01001, 3'b000);
            #1;
            checkOutput($sformatf("rrAck%0d", k), ackIn & 5'b01001, ackSeq[k]);
            stepCycle();
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(5'b00000, 3'b001);
            #1;
            checkOutput($sformatf("rrOrder%0d", k), outData[0 +: PB], ordSeq[k]);
            stepCycle();
        end

        // Output 1 stalled while input 1 streams: four acks, then back-pressure with stable head.
        pulseReset();
        ackCount = 0;
        for (int k = 0; k < 6; k++) begin
            applyStimulus(5'b00010, 3'b000);
            #1;
            if (ackIn[1]) ackCount++;
            stepCycle();
        end
        checkOutput("stallAcks", 64'(ackCount), 64'd4);
        applyStimulus(5'b00010, 3'b000);
        #1;
        checkOutput("stallAck1", ackIn[1], 1'b0);
        checkOutput("stallVld1", outVld[1], 1'b1);
        checkOutput("stallHead", outData[PB +: PB], PB'(32'h10));
        stepCycle();

        // Full FIFO 2: pop without push this cycle, push accepted next cycle.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(5'b00100, 3'b000);
            stepCycle();
        end
        applyStimulus(5'b00100, 3'b100);
        #1;
        checkOutput("fullNoPush", ackIn[2], 1'b0);
        checkOutput("fullPopVld", outVld[2], 1'b1);
        stepCycle();
        applyStimulus(5'b00100, 3'b000);
        #1;
        checkOutput("pushAfterPop", ackIn[2], 1'b1);
        stepCycle();

        // Reset with two words queued in FIFO 1 and its pointer moved off input 1.
        pulseReset();
        for (int k = 0; k < 2; k++) begin
            applyStimulus(5'b00010, 3'b000);
            stepCycle();
        end
        reset = 1'b1;
        applyStimulus(5'b10010, 3'b010);
        stepCycle();
        reset = 1'b0;
        applyStimulus(5'b10010, 3'b000);
        #1;
        checkOutput("postRstVld", outVld, '0);
        checkOutput("postRstCnt", wordCnt, '0);
        checkOutput("postRstPtr", ackIn & 5'b10010, 5'b00010);
        stepCycle();

        // Random traffic with occasional resets.
        for (int k = 0; k < 600; k++) begin
            reset = ($urandom_range(99) == 0);
            inVld = NIN'($urandom);
            for (int i = 0; i < NIN; i++) inData[i*PB +: PB] = $urandom;
            for (int j = 0; j < NOUT; j++) outAck[j] = ($urandom_range(9) < 6);
            stepCycle();
        end
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/leaf_user_rr_merge.md
LEAF_USER_RR_MERGE -- requirements
Module: leaf_user_rr_merge

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 32, the width of one data word.
REQ-002 SHALL have parameter NUM_IN_PORTS, default 5, the number of interface-to-user input ports; the legal range is 1..16.
REQ-003 SHALL have parameter NUM_OUT_PORTS, default 3, the number of user-to-interface output ports; the legal range is 1..NUM_IN_PORTS.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, the entries per output FIFO; it is a power of 2 and at least 2.
REQ-005 SHALL use one clock and a synchronous, active-high reset.
REQ-006 SHALL have port clk_user, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port dout_leaf_interface2user, input, NUM_IN_PORTS*PAYLOAD_BITS bits: input data, with port i in bits [i*PAYLOAD_BITS +: PAYLOAD_BITS].
REQ-009 SHALL have port vld_interface2user, input, NUM_IN_PORTS bits: per-input valid.
REQ-010 SHALL have port ack_user2interface, output, NUM_IN_PORTS bits: per-input accept.
REQ-011 SHALL have port din_leaf_user2interface, output, NUM_OUT_PORTS*PAYLOAD_BITS bits: output data, packed the same way as REQ-008.
REQ-012 SHALL have port vld_user2interface, output, NUM_OUT_PORTS bits: per-output valid.
REQ-013 SHALL have port ack_interface2user, input, NUM_OUT_PORTS bits: per-output accept.
REQ-014 SHALL have port word_cnt, output, NUM_OUT_PORTS*32 bits: per-output transfer counters.

Function
REQ-015 SHALL treat a transfer on any port as occurring in the cycle where both vld and ack are high.
REQ-016 SHALL route input i to output j = i mod NUM_OUT_PORTS; the inputs routed to output j form group j.
REQ-017 SHALL give each output j its own FIFO of FIFO_DEPTH words.
- FIFO j pushes only on an input transfer from group j.
- FIFO j pops only on an output transfer on port j.
REQ-018 SHALL run a round-robin arbiter per group.
- It asserts ack_user2interface[i] for at most one input per group per cycle.
- Only inputs with vld high are eligible.
- No ack is given while FIFO j is full.
- The ack depends combinationally on the current-cycle vld and the registered full flag only.
REQ-019 SHALL grant the first requesting input at or after pointer ptr_j, in ascending order with wrap-around.
- After a grant to input i, ptr_j becomes the next group member after i, wrapping to the lowest member.
- ptr_j is unchanged in a cycle with no grant.
REQ-020 SHALL make FIFO j first-word-fall-through.
- vld_user2interface[j] equals !empty_j.
- din_leaf_user2interface[j] is the head word and stays stable until it is popped.
REQ-021 SHALL present a word accepted in cycle t at the output in cycle t+1 when FIFO j was empty.
REQ-022 SHALL evaluate full from the registered count, so a pop and a push requested in the same cycle while full result in no push.
REQ-023 SHALL perform a push and a pop in the same cycle when not full and not empty, leaving the count unchanged.
REQ-024 SHALL never change ack_user2interface or vld_user2interface in response to an ack_interface2user that arrives while vld_user2interface is low.
REQ-025 SHALL preserve per-input word order end to end; ordering between inputs of the same group follows grant order.

Reset
REQ-026 SHALL, when reset is high on a clock edge:
- empty all FIFOs;
- set every ptr_j to the lowest member of group j;
- clear word_cnt to 0.
REQ-027 SHALL drive all ack_user2interface and vld_user2interface bits to 0 during any cycle where reset is high.
REQ-028 SHALL discard words held mid-operation when reset is asserted, and drop any transfer attempted in the reset cycle.

Configuration
REQ-029 SHALL, when macro LEAF_RR_MERGE_CNT_EN is defined, give word_cnt[j] a 32-bit counter that increments on each output-j transfer and saturates at 0xFFFFFFFF.
REQ-030 SHALL, when LEAF_RR_MERGE_CNT_EN is undefined, keep port word_cnt present but tie it to 0, with no counter logic.

Structure
REQ-031 SHALL take the following from the shared package leaf_shell_pkg:
- the PAYLOAD_BITS default;
- the counter width constant (32);
- a clog2 helper for pointer and count widths.
REQ-032 SHALL implement each FIFO as one instance of sub-module leaf_sync_fifo (parameters WIDTH and DEPTH; registered count; full and empty flags), generated NUM_OUT_PORTS times.

Verification
REQ-033 SHALL pass this scenario: defaults; vld on input 0 for 3 cycles with data 0xA0, 0xA1, 0xA2, and ack_interface2user[0] held high.
- Required: output 0 shows 0xA0, 0xA1, 0xA2, each one cycle after its acceptance.
- Required: word_cnt[0] = 3 with the macro, 0 without.
REQ-034 SHALL pass this scenario: inputs 0 and 3 (both in group 0) held valid continuously.
- Required: acks alternate 0, 3, 0, 3.
- Required: output order is 0x00, 0x30, 0x01, 0x31.
REQ-035 SHALL pass this scenario: ack_interface2user[1] held low and input 1 streaming.
- Required: exactly 4 acks are given, then ack_user2interface[1] = 0 while vld_user2interface[1] = 1 with data stable.
REQ-036 SHALL pass this scenario: FIFO 2 full, then ack_interface2user[2] raised while input 2 is valid.
- Required: the pop occurs that cycle with no push, and the push is accepted the next cycle.
REQ-037 SHALL pass this scenario: reset pulsed for 1 cycle with 2 words queued in FIFO 1.
- Required: next cycle, vld_user2interface = 0, word_cnt = 0, and ptr_1 is at input 1.
